alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Shares one 8-bit, 16-opcode ALU datapath between NUM_REQ requesters.
- Round-robin arbitration, a valid/ready request handshake, registered operand capture and a registered result returned to the granted requester.
- Sits between the requesting engines and the arithmetic datapath. One operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, operand/result width; fixed at 8 for the current opcode table.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept pulse; request taken when valid&ready.
- req_a  in  NUM_REQ*DW  operand A, requester i at [i*DW +: DW].
- req_b  in  NUM_REQ*DW  operand B, same packing.
- req_op  in  NUM_REQ*4  opcode, requester i at [i*4 +: 4].
- rsp_valid  out  NUM_REQ  one-hot; result for requester i is valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DW  result; meaningful only while any rsp_valid bit is high.
- rsp_dz  out  1  divide-by-zero flag, qualified by rsp_valid.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_dz=0, busy=0, state=IDLE, rr pointer=0. A reset mid-operation discards the in-flight operation; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, pick the winner: the first valid index at or after the rr pointer, wrapping modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in this same cycle.
  - On the edge: latch a, b, op and winner id; go to EXEC.
  - If no req_valid, stay in IDLE; req_ready is all zero.
- EXEC:
  - Compute the ALU function on the latched operands.
  - Register the result into rsp_data and set rsp_dz; go to RESP.
- RESP:
  - rsp_valid[id]=1, held with data stable until rsp_ready[id]=1.
  - On that edge: rsp_valid cleared, rr pointer = (id+1) mod NUM_REQ, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency and throughput:
  - Accept to rsp_valid: 2 cycles.
  - Minimum issue interval: 3 cycles, when rsp_ready is already high.
- req_ready is never asserted outside IDLE.
- A requester may drop req_valid before it is granted; no state is kept for it.
- Opcode table (all results truncated to 8 bits, modulo 256):
  - 0 add, 1 sub, 2 mul (low 8 bits), 3 unsigned div.
  - 4 and, 5 or, 6 nand, 7 nor.
  - 8 a+1, 9 a-1, A xor.
  - B logical shift right 1, C shift left 1.
  - D a+b+1, E a-b-1, F b+1.
- Divide by zero: op 3 with b=0 gives result 8'hFF and rsp_dz=1. For every other case rsp_dz=0.
- Simultaneous requests: exactly one grant per IDLE cycle. Requests that lose remain pending, and their valid must stay high to be served.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,...
- No X is ever driven on rsp_data; an unmatched case yields 0.

Decomposition:
- Package alu_sched_pkg holds:
  - typedef enum logic[3:0] alu_op_e for the 16 opcodes;
  - typedef enum logic[1:0] sched_state_e {IDLE, EXEC, RESP};
  - localparam DZ_RESULT = 8'hFF.
- One sub-module, rr_arbiter: parameter N; inputs req[N], ptr; outputs gnt one-hot and gnt_idx. Purely combinational.
- The ALU function is an always_comb case on alu_op_e inside the top.

Test Plan:
- Reset then single request: req0 a=8'h0F, b=8'h01, op=0 -> req_ready[0] in the same cycle; rsp_valid[0] 2 cycles later with rsp_data=8'h10, rsp_dz=0.
- Wrap and truncation: op=2 with a=8'h10, b=8'h10 -> 8'h00; op=1 with a=8'h00, b=8'h01 -> 8'hFF; op=E with a=8'h05, b=8'h05 -> 8'hFF.
- Divide by zero: op=3, a=8'h40, b=0 -> rsp_data=8'hFF, rsp_dz=1. Then op=3, a=8'h40, b=8'h03 -> 8'h15, rsp_dz=0.
- Fairness: all four requesters continuously valid with distinct ops -> grant order 0,1,2,3,0 and each rsp_valid bit matches its grant.
- Backpressure: rsp_ready[1] held low for 5 cycles -> rsp_valid[1] and rsp_data stable for all 5 cycles, req_ready stays all zero, and the next grant comes only after the handshake.
- Reset mid-op: assert rst in EXEC -> next cycle all outputs are 0, no rsp_valid is issued, and the following request from req2 is granted under pointer 0 order.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the round-robin ALU scheduler: opcodes, FSM states, divide-by-zero result.
package alu_sched_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_INC  = 4'h8,
        OP_DEC  = 4'h9,
        OP_XOR  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SHL  = 4'hC,
        OP_ADC  = 4'hD,
        OP_SBB  = 4'hE,
        OP_INCB = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam logic [7:0] DZ_RESULT = 8'hFF;

endpackage

// File: rtl/alu_rr_sched_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
// Zero latency; no backpressure of its own, gnt is all zero when nothing requests.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin shared 8-bit ALU: one op in flight, accept-to-rsp_valid 2 cycles, issue every 3.
// Backpressure: result held stable until the granted requester's rsp_ready; no new grant meanwhile.
import alu_sched_pkg::*;

module alu_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_dz,
    output logic                  busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [DW-1:0] ONE = DW'(1);

    sched_state_e   state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  id;
    logic [IW-1:0]  gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    alu_op_e        op_q;
    logic [DW-1:0]  alu_res;
    logic           alu_dz;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Accept is combinational so the winner sees ready in the cycle it is chosen.
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;

    always_comb begin
        alu_res = '0;
        alu_dz  = 1'b0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            OP_DIV: begin
                if (b_q == '0) begin
                    alu_res = DW'(DZ_RESULT);
                    alu_dz  = 1'b1;
                end else begin
                    alu_res = a_q / b_q;
                end
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_INC:  alu_res = a_q + ONE;
            OP_DEC:  alu_res = a_q - ONE;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHR:  alu_res = a_q >> 1;
            OP_SHL:  alu_res = a_q << 1;
            OP_ADC:  alu_res = a_q + b_q + ONE;
            OP_SBB:  alu_res = a_q - b_q - ONE;
            OP_INCB: alu_res = b_q + ONE;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_dz    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_q   <= req_a[gnt_idx*DW +: DW];
                        b_q   <= req_b[gnt_idx*DW +: DW];
                        op_q  <= alu_op_e'(req_op[gnt_idx*4 +: 4]);
                        id    <= gnt_idx;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_res;
                    rsp_dz    <= alu_dz;
                    rsp_valid <= NUM_REQ'(1) << id;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready completes the handshake.
                    if (rsp_ready[id]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (int'(id) == NUM_REQ - 1) ? '0 : id + IW'(1);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Randomized self-checking bench for alu_rr_sched against a transaction-level reference model.
module tb_alu_rr_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N*4-1:0] req_op;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [7:0]     rsp_data;
    logic           rsp_dz;
    logic           busy;

    int         checks = 0;
    int         errors = 0;
    int         mptr   = 0;
    int         last_w = 0;
    logic [7:0] last_data;
    logic       last_dz;

    alu_rr_sched #(.NUM_REQ(N), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_dz    (rsp_dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, output logic dz);
        int x, y, r;
        x  = int'(a);
        y  = int'(b);
        r  = 0;
        dz = 1'b0;
        case (op)
            4'h0: r = x + y;
            4'h1: r = x - y;
            4'h2: r = x * y;
            4'h3: begin
                if (y == 0) begin
                    r  = 255;
                    dz = 1'b1;
                end else begin
                    r = x / y;
                end
            end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = ~(x & y);
            4'h7: r = ~(x | y);
            4'h8: r = x + 1;
            4'h9: r = x - 1;
            4'hA: r = x ^ y;
            4'hB: r = x / 2;
            4'hC: r = x * 2;
            4'hD: r = x + y + 1;
            4'hE: r = x - y - 1;
            4'hF: r = y + 1;
            default: r = 0;
        endcase
        return 8'(r & 255);
    endfunction

    // First valid requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req_valid[i]        = 1'b1;
        req_a[i*8 +: 8]     = a;
        req_b[i*8 +: 8]     = b;
        req_op[i*4 +: 4]    = op;
    endtask

    // One full transaction from the IDLE cycle to the response handshake; returns at posedge+1.
    task automatic run_one(input int hold, input logic [N-1:0] other);
        int         w;
        logic [N-1:0] m;
        logic [7:0] er;
        logic       edz;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);
        w = pick(req_valid, mptr);
        if (w < 0) w = 0;
        m = N'(1) << w;
        check_eq("grant", 32'(req_ready), 32'(m));
        er = ref_alu(req_op[w*4 +: 4], req_a[w*8 +: 8], req_b[w*8 +: 8], edz);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        rsp_ready = (hold == 0) ? (other | m) : (other & ~m);
        @(negedge clk);
        check_eq("exec_vld", 32'(rsp_valid), 0);
        check_eq("exec_rdy", 32'(req_ready), 0);
        check_eq("exec_busy", 32'(busy), 1);
        @(negedge clk);
        check_eq("rsp_vld", 32'(rsp_valid), 32'(m));
        check_eq("rsp_data", 32'(rsp_data), 32'(er));
        check_eq("rsp_dz", 32'(rsp_dz), 32'(edz));
        check_eq("resp_rdy", 32'(req_ready), 0);
        last_w    = w;
        last_data = rsp_data;
        last_dz   = rsp_dz;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); #1;
            if (i == hold) rsp_ready = rsp_ready | m;
            @(negedge clk);
            check_eq("hold_vld", 32'(rsp_valid), 32'(m));
            check_eq("hold_data", 32'(rsp_data), 32'(er));
            check_eq("hold_rdy", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = '0;
        mptr = (w + 1) % N;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_data", 32'(rsp_data), 0);
        check_eq("rst_rsp_dz", 32'(rsp_dz), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        mptr = 0;

        set_req(0, 8'h0F, 8'h01, 4'h0);
        run_one(0, '0);
        check_eq("add_lit", 32'(last_data), 32'h10);
        check_eq("add_dz", 32'(last_dz), 0);

        set_req(1, 8'h10, 8'h10, 4'h2);
        run_one(0, '0);
        check_eq("mul_wrap", 32'(last_data), 32'h00);
        set_req(2, 8'h00, 8'h01, 4'h1);
        run_one(0, '0);
        check_eq("sub_wrap", 32'(last_data), 32'hFF);
        set_req(3, 8'h05, 8'h05, 4'hE);
        run_one(0, '0);
        check_eq("sbb_wrap", 32'(last_data), 32'hFF);
        set_req(0, 8'h40, 8'h00, 4'h3);
        run_one(0, '0);
        check_eq("div0_data", 32'(last_data), 32'hFF);
        check_eq("div0_dz", 32'(last_dz), 1);
        set_req(1, 8'h40, 8'h03, 4'h3);
        run_one(0, '0);
        check_eq("div_data", 32'(last_data), 32'h15);
        check_eq("div_dz", 32'(last_dz), 0);

        // Fairness from a fresh pointer with everyone requesting.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0;
        set_req(0, 8'h11, 8'h22, 4'h0);
        set_req(1, 8'h33, 8'h0F, 4'h4);
        set_req(2, 8'h5A, 8'hA5, 4'hA);
        set_req(3, 8'h07, 8'h08, 4'hD);
        for (int i = 0; i < 5; i++) begin
            run_one(0, 4'($urandom));
            check_eq("fair_order", 32'(last_w), 32'(i % N));
            req_valid[last_w] = 1'b1;
        end
        req_valid = '0;

        // Backpressure on requester 1 while requester 2 waits.
        set_req(1, 8'h81, 8'h02, 4'h2);
        set_req(2, 8'h03, 8'h04, 4'h0);
        run_one(5, 4'b1101);
        check_eq("bp_winner", 32'(last_w), 1);
        run_one(0, '0);
        check_eq("bp_next", 32'(last_w), 2);

        // Reset while requester 3's operation is executing.
        set_req(3, 8'h09, 8'h01, 4'h0);
        @(negedge clk);
        check_eq("mid_grant", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rsp_valid", 32'(rsp_valid), 0);
        check_eq("mid_rsp_data", 32'(rsp_data), 0);
        check_eq("mid_rsp_dz", 32'(rsp_dz), 0);
        check_eq("mid_busy", 32'(busy), 0);
        check_eq("mid_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0;
        repeat (2) begin
            @(negedge clk);
            check_eq("mid_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        set_req(2, 8'h20, 8'h02, 4'hC);
        set_req(3, 8'h01, 8'h01, 4'h1);
        run_one(0, '0);
        check_eq("post_rst_winner", 32'(last_w), 2);

        // Random traffic with requesters arriving and withdrawing.
        req_valid = '0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0))
                    set_req(i, 8'($urandom), 8'($urandom % 4 == 0 ? 0 : $urandom), 4'($urandom));
                else if (req_valid[i] && ($urandom % 8 == 0))
                    req_valid[i] = 1'b0;
            end
            if (req_valid == '0)
                set_req(int'($urandom % N), 8'($urandom), 8'($urandom), 4'($urandom));
            run_one(int'($urandom % 3), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
